// File: rtl/pirdsp_pkg.sv
// Shared types, limits and the saturating add helper
// for the PIRDSP post-multiplier stages.
package pirdsp_pkg;

    localparam int P_W   = 32;
    localparam int ACC_W = 48;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } sat_res_t;

    // Signed add with overflow flag; clamps to the limit on
    // the side of acc's sign when saturate is set.
    function automatic sat_res_t sat_add(
        input logic [ACC_W-1:0] acc,
        input logic [ACC_W-1:0] ext,
        input logic             saturate
    );
        sat_res_t r;
        r.sum = acc + ext;
        r.ovf = (acc[ACC_W-1] == ext[ACC_W-1]) &&
                (r.sum[ACC_W-1] != acc[ACC_W-1]);
        if (r.ovf && saturate) begin
            r.sum = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/pirdsp_sat_adder.sv
// Combinational extend + add + overflow detect + clamp,
// generic in product and accumulator widths.
module pirdsp_sat_adder
    import pirdsp_pkg::*;
#(
    parameter int P_WIDTH   = 32,
    parameter int ACC_WIDTH = 48,
    parameter bit SATURATE  = 1'b0
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    input  logic [P_WIDTH-1:0]   product_i,
    input  logic                 signed_i,
    output logic [ACC_WIDTH-1:0] sum_o,
    output logic                 ovf_o
);

    localparam int EXT_W = ACC_WIDTH - P_WIDTH;
    localparam int MSB   = ACC_WIDTH - 1;

    localparam logic [ACC_WIDTH-1:0] LIM_MAX =
        {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] LIM_MIN =
        {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic                 fill;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0] raw;
    logic                 ovf;

    // Extend the product, add modulo 2^ACC_WIDTH, clamp on overflow.
    always_comb begin
        fill  = signed_i & product_i[P_WIDTH-1];
        ext   = {{EXT_W{fill}}, product_i};
        raw   = acc_i + ext;
        ovf   = (acc_i[MSB] == ext[MSB]) && (raw[MSB] != acc_i[MSB]);
        sum_o = raw;
        if (ovf && SATURATE) begin
            sum_o = acc_i[MSB] ? LIM_MIN : LIM_MAX;
        end
        ovf_o = ovf;
    end

endmodule

// File: rtl/pirdsp_product_accumulator.sv
// Packet accumulator for the 16x16 multiplier product stream:
// extends, sums into ACC_WIDTH bits and hands off per packet.
module pirdsp_product_accumulator
    import pirdsp_pkg::*;
#(
    parameter int P_WIDTH   = 32,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 8,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [P_WIDTH-1:0]   in_product,
    input  logic                 in_signed,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_overflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_ovf;
    logic                 accept;

    pirdsp_sat_adder #(
        .P_WIDTH   (P_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SATURATE  (SATURATE)
    ) u_add (
        .acc_i     (acc_q),
        .product_i (in_product),
        .signed_i  (in_signed),
        .sum_o     (add_sum),
        .ovf_o     (add_ovf)
    );

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == DONE);
    assign accept       = in_valid & in_ready;
    assign out_acc      = acc_q;
    assign out_count    = cnt_q;
    assign out_overflow = ovf_q;

    // Next state: accumulate beats in ACCUM, hold and clear in DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_ovf;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: doc/pirdsp_product_accumulator.md
# pirdsp_product_accumulator

Downstream stage of the 16x16 Baugh-Wooley multiplier: takes the 32-bit product stream, sign- or zero-extends each product, and accumulates it into a 48-bit register over a packet delimited by `in_last`. It provides dot-product and MAC reduction for PIRDSP models, with valid/ready handshakes on both sides, an optional saturation mode and a sticky overflow flag.

## Interface
- `P_WIDTH`, 32, product width; matches multiplier `A_chop_size+B_chop_size`.
- `ACC_WIDTH`, 48, accumulator width; must be greater than `P_WIDTH`.
- `CNT_WIDTH`, 8, beat-counter width.
- `SATURATE`, 0, 1 = clamp on signed overflow, 0 = wrap.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  stage accepts a beat.
- `in_product`  in  P_WIDTH  multiplier output `C`.
- `in_signed`  in  1  product is signed; drive with `A_sign|B_sign`.
- `in_last`  in  1  final beat of the packet.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_acc`  out  ACC_WIDTH  accumulated sum, two's complement.
- `out_count`  out  CNT_WIDTH  beats in the packet, saturating.
- `out_overflow`  out  1  sticky: at least one add overflowed in this packet.

## Operation
- The block has two states:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- A beat is accepted when `in_valid & in_ready`.
- Extension: `ext` = `in_signed` ? sign-extend(`in_product`) : zero-extend(`in_product`) to ACC_WIDTH.
- Add: `sum` = `acc + ext`, computed modulo 2^ACC_WIDTH.
- Overflow condition: `acc[MSB]==ext[MSB]` and `sum[MSB]!=acc[MSB]`.
- On overflow:
  - `ovf` is set and stays set until the packet is cleared.
  - If SATURATE=1, `acc` loads the signed limit: 0x7FFF_FFFF_FFFF when `acc` was non-negative, 0x8000_0000_0000 otherwise.
  - If SATURATE=0, `acc` loads `sum`.
- Count: `cnt` increments on each accepted beat and saturates at 2^CNT_WIDTH-1.
- ACCUM to DONE: on an accepted beat with `in_last`=1, after that beat is added.
- DONE to ACCUM: on `out_valid & out_ready`. In the same edge, `acc`, `cnt` and `ovf` clear to 0.
- A packet of exactly one beat is legal; the result equals `ext` of that beat.
- `in_valid` is ignored while in DONE. The upstream holds its beat under standard valid/ready rules.
- `out_acc`, `out_count` and `out_overflow` are driven directly from `acc`, `cnt` and `ovf`. They stay stable for the whole of DONE.

## Timing
- Reset values: state=ACCUM, `acc`=0, `cnt`=0, `ovf`=0, `out_valid`=0, `in_ready`=1 from the first edge with reset high.
- Throughput: one beat per cycle while in ACCUM.
- Latency: `out_valid` rises on the edge that accepts the last beat and is visible the following cycle.
- After the output handshake, `in_ready` is 1 in the next cycle. This gives a one-cycle bubble between packets.
- `out_valid` stays high, with data stable, until `out_ready` is sampled high. `out_ready` is a don't-care in ACCUM.
- A reset asserted mid-packet or in DONE discards the partial or unread result and restores the reset values on that edge.
- `in_ready` is a function of state only, with no combinational path from `out_ready`.
- `out_valid` is a function of state only.

## Structure
- Shared package `pirdsp_pkg` holds:
  - a state enum {ACCUM, DONE};
  - localparams for `ACC_MAX` and `ACC_MIN` as functions of ACC_WIDTH;
  - a function `sat_add(acc, ext, saturate)` returning {sum, ovf}.
- One natural sub-module, `pirdsp_sat_adder`: a combinational extend, add, overflow-detect and clamp unit, reusable by later post-adder stages.
- State register, counter and handshake logic live in the top module.

## Test plan
- Reset, then a 3-beat unsigned packet of 0x0000_0005, 0x0000_0007, 0xFFFF_FFFF -> `out_acc`=0x0001_0000_000B, `out_count`=3, `out_overflow`=0, `out_valid` the cycle after beat 3.
- Signed 2-beat packet of 0xFFFF_FFFE (-2) and 0x0000_0001 -> `out_acc`=0xFFFF_FFFF_FFFF (-1).
- SATURATE=1: 0x7FFF_FFFF signed added 65538 times -> `out_acc`=0x7FFF_FFFF_FFFF, `out_overflow`=1, `out_count`=255.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while `in_valid`=1 -> `in_ready`=0, outputs stable, no beat consumed; release -> next packet starts from `acc`=0.
- Single-beat packet 0x8000_0000 signed -> `out_acc`=0xFFFF_8000_0000, `out_count`=1.
- Reset asserted after 2 beats of a packet -> next edge `acc`=0 and `in_ready`=1; a following 1-beat packet 0x10 gives `out_acc`=0x10.
